// File: rtl/dmem_bus_ctrl.sv
// Data-memory request controller: one aligned load/store per access on a single-outstanding bus.
// Optional watchdog abort is enabled by defining DMEM_TIMEOUT_EN.
module dmem_bus_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [1:0]          req_size,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic                flush,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                stall,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_wen,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_err
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic                drop;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic accept;
    logic misaligned;
    logic busy;
    logic timeout;

    assign accept = req_valid & ~flush & (state == IDLE);
    assign busy   = (state == REQ) | (state == WAIT);

    assign misaligned =
        (req_addr[0] & (req_size != 2'd0)) |
        ((req_addr[1:0] != 2'b00) & req_size[1]) |
        ((req_addr[2:0] != 3'b000) & (req_size == 2'd3));

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] wdog;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= 8'd0;
        end else if (accept) begin
            wdog <= 8'd0;
        end else if (busy) begin
            wdog <= wdog + 8'd1;
        end
    end

    assign timeout = busy & (wdog == 8'hFF);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            drop    <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= {req_addr[ADDR_W-1:3], 3'b000};
                        wen_q   <= req_wen;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        if (misaligned) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (flush) drop <= 1'b1;
                    if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end else if (bus_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) drop <= 1'b1;
                    if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end else if (bus_rvalid) begin
                        rdata_q <= wen_q ? '0 : bus_rdata;
                        err_q   <= bus_err;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    drop  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign stall     = (req_valid & (state == IDLE)) | busy;
    // A flush in the completion cycle suppresses the pulse as well.
    assign rsp_valid = (state == DONE) & ~drop & ~flush;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign bus_valid = (state == REQ);
    assign bus_addr  = addr_q;
    assign bus_wen   = wen_q;
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Sequential data-memory request controller, directly downstream of the memory-access stage.
- Accepts one aligned-doubleword load/store request (address, write data, byte strobes already aligned by the stage) and runs it on a single-outstanding valid/ready data bus.
- Returns the raw 64-bit read doubleword to the stage for extraction and sign extension.
- Drives a pipeline stall while the access is in flight.

Parameters:
- ADDR_W, 64, request/bus address width
- DATA_W, 64, data width; strobe width is DATA_W/8

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  access request from the memory-access stage
- req_ready  out  1  controller can accept a request
- req_wen  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=double (alignment check)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  lane-aligned store data
- req_wstrb  in  DATA_W/8  store byte enables
- flush  in  1  discard the current/pending result (trap/redirect)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  raw read doubleword (0 for stores)
- rsp_err  out  1  misaligned or bus error
- stall  out  1  hold upstream pipeline
- bus_valid  out  1  bus request valid
- bus_ready  in  1  bus accepts request
- bus_addr  out  ADDR_W  req_addr with [2:0] forced to 0
- bus_wen, bus_wdata, bus_wstrb  out  1/DATA_W/DATA_W/8  registered copies of the request
- bus_rvalid  in  1  completion beat (reads and writes)
- bus_rdata  in  DATA_W  read data
- bus_err  in  1  error qualifier on bus_rvalid

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset (asynchronous, rst_n=0): state IDLE; all outputs 0 except req_ready=1; all registered request fields 0; drop flag 0.
- req_ready = (state==IDLE).
- stall = req_valid&(state==IDLE) | (state==REQ) | (state==WAIT).
- IDLE, accept on req_valid & !flush:
  - Latch all request fields.
  - Misaligned if addr[0] & size>=1, addr[1:0]!=0 & size>=2, or addr[2:0]!=0 & size==3. Misaligned goes to DONE with err=1 and no bus transaction.
  - Otherwise go to REQ.
- req_valid with flush in IDLE: ignored; nothing latched.
- REQ: bus_valid=1, and bus_* stay stable until bus_ready. The bus_valid&bus_ready handshake moves to WAIT. bus_valid may never drop before the handshake, even on flush.
- WAIT:
  - bus_rvalid is sampled only from the cycle after the handshake.
  - On bus_rvalid: rsp_rdata register <= (wen ? 0 : bus_rdata), rsp_err register <= bus_err, then go to DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle, unless the drop flag is set or flush is high that cycle; then rsp_valid=0.
  - Always returns to IDLE; no new request is accepted in DONE.
- Drop flag: set by flush in REQ or WAIT; cleared on leaving DONE. A flushed access still completes on the bus; only its response is suppressed.
- bus_rvalid in IDLE, REQ or DONE: ignored.
- Minimum latency: accept at cycle 0, bus_valid at 1, bus_ready at 1, bus_rvalid at 2, rsp_valid at 3. Misaligned access: rsp_valid at cycle 1.
- rsp_rdata and rsp_err hold their value after DONE until the next completion.

Optional Feature:
- Macro DMEM_TIMEOUT_EN. When defined:
  - An 8-bit watchdog counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - At 255 the controller forces DONE with rsp_err=1, rsp_rdata=0, and bus_valid deasserted.
  - A late bus_rvalid arriving in IDLE is ignored.
- When not defined: no counter, and the controller waits indefinitely.

Test Plan:
- Load addr 0x80001008, size 3; bus_ready at cycle 1; bus_rvalid at cycle 2 with 0x1122334455667788 -> bus_addr 0x80001008; rsp_valid at cycle 3; rsp_rdata 0x1122334455667788; rsp_err=0; stall high during cycles 0-2.
- Store addr 0x80000006, size 1, wstrb 0xC0, wdata 0xBEEF000000000000; bus_ready held low 4 cycles -> bus fields stable throughout; bus_addr 0x80000000; rsp_rdata=0 after rvalid.
- Load addr 0x80000003, size 2 -> no bus_valid ever; rsp_valid at cycle 1 with rsp_err=1.
- Load with flush asserted in WAIT -> bus handshake and rvalid still occur; rsp_valid stays 0; next request accepted in the cycle after DONE.
- rst_n pulsed low while in WAIT -> outputs return to reset values immediately; a subsequent bus_rvalid is ignored; req_ready=1.
- With DMEM_TIMEOUT_EN defined and bus_ready tied 0 -> rsp_valid with rsp_err=1 exactly 256 cycles after entering REQ; bus_valid drops.
